// File: rtl/vga_scan_controller.sv
// 640x480@60 raster timing generator: issues CurrentX/CurrentY and drives delay-matched sync/RGB pins.
// Optional macro VGA_TESTPATTERN_EN replaces mapData with eight 80-px vertical colour bars.
module vga_scan_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int MAP_LATENCY = 1
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic [7:0] mapData,
  output logic [9:0] CurrentX,
  output logic [8:0] CurrentY,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       active,
  output logic       frame_start
);

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_LO_C  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI_C  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_LO_C  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI_C  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       vis0, hs0, vs0, fs0;

  logic [9:0] x_q;
  logic [8:0] y_q;

  logic [MAP_LATENCY:0] vis_dly_q, hs_dly_q, vs_dly_q, fs_dly_q;

  logic       hsync_q, vsync_q, active_q, frame_start_q;
  logic [7:0] rgb_q, rgb_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    vis0 = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs0  = !((h_cnt_q >= HS_LO_C) && (h_cnt_q <= HS_HI_C));
    vs0  = !((v_cnt_q >= VS_LO_C) && (v_cnt_q <= VS_HI_C));
    fs0  = vis0 && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      vis_dly_q <= '0;
      hs_dly_q  <= '1;
      vs_dly_q  <= '1;
      fs_dly_q  <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      // Blanking coordinates are parked at 0 so room decoders never see aliased counts.
      x_q       <= vis0 ? h_cnt_q : 10'd0;
      y_q       <= vis0 ? v_cnt_q[8:0] : 9'd0;
      vis_dly_q <= {vis_dly_q[MAP_LATENCY-1:0], vis0};
      hs_dly_q  <= {hs_dly_q[MAP_LATENCY-1:0], hs0};
      vs_dly_q  <= {vs_dly_q[MAP_LATENCY-1:0], vs0};
      fs_dly_q  <= {fs_dly_q[MAP_LATENCY-1:0], fs0};
    end
  end

`ifdef VGA_TESTPATTERN_EN
  logic [2:0] bar0;
  logic [2:0] bar_dly_q [MAP_LATENCY+1];

  always_comb begin
    bar0 = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= 10'(i * 80)) bar0 = 3'(i);
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      for (int i = 0; i <= MAP_LATENCY; i++) bar_dly_q[i] <= 3'd0;
    end else begin
      bar_dly_q[0] <= bar0;
      for (int i = 1; i <= MAP_LATENCY; i++) bar_dly_q[i] <= bar_dly_q[i-1];
    end
  end

  always_comb begin
    rgb_d = 8'd0;
    if (vis_dly_q[MAP_LATENCY])
      rgb_d = {{3{bar_dly_q[MAP_LATENCY][2]}}, {3{bar_dly_q[MAP_LATENCY][1]}},
               {2{bar_dly_q[MAP_LATENCY][0]}}};
  end
`else
  always_comb begin
    rgb_d = 8'd0;
    if (vis_dly_q[MAP_LATENCY]) rgb_d = mapData;
  end
`endif

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= 8'd0;
    end else begin
      hsync_q       <= hs_dly_q[MAP_LATENCY];
      vsync_q       <= vs_dly_q[MAP_LATENCY];
      active_q      <= vis_dly_q[MAP_LATENCY];
      frame_start_q <= fs_dly_q[MAP_LATENCY];
      rgb_q         <= rgb_d;
    end
  end

  assign CurrentX    = x_q;
  assign CurrentY    = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[7:5];
  assign vga_g       = rgb_q[4:2];
  assign vga_b       = rgb_q[1:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: latency-1 and latency-3 instances with stub map blocks.
// Vertical timing is shortened (12 lines/frame) so two full frames stay short; horizontal timing is the real 800 clocks.
`timescale 1ns/1ps
module tb_vga_scan_controller;

  localparam int HT    = 800;
  localparam int VT    = 12;
  localparam int FRAME = HT * VT;

  logic clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  logic       rst;
  logic [7:0] map1, map3, s3a, s3b;
  logic [9:0] x1, x3;
  logic [8:0] y1, y3;
  logic       hs1, vs1, act1, fs1, hs3, vs3, act3, fs3;
  logic [2:0] r1, g1, r3, g3;
  logic [1:0] b1, b3;
  logic [7:0] col1, col3;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  assign col1 = {r1, g1, b1};
  assign col3 = {r3, g3, b3};

  vga_scan_controller #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .MAP_LATENCY(1)) dut (
    .clk_vga(clk_vga), .rst(rst), .mapData(map1), .CurrentX(x1), .CurrentY(y1),
    .hsync(hs1), .vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .active(act1), .frame_start(fs1));

  vga_scan_controller #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .MAP_LATENCY(3)) dut3 (
    .clk_vga(clk_vga), .rst(rst), .mapData(map3), .CurrentX(x3), .CurrentY(y3),
    .hsync(hs3), .vsync(vs3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .active(act3), .frame_start(fs3));

  // Map stubs: one-deep threshold block, and a three-deep column-derived block.
  always @(posedge clk_vga) map1 <= (x1 >= 10'd40) ? 8'hB6 : 8'h00;
  always @(posedge clk_vga) begin
    s3a  <= x3[7:0] + 8'h5A;
    s3b  <= s3a;
    map3 <= s3b;
  end

  function automatic logic [7:0] exp_col(int h, int lat);
`ifdef VGA_TESTPATTERN_EN
    logic [2:0] b;
    b = 3'(h / 80);
    return {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
`else
    if (lat == 1) return (h >= 40) ? 8'hB6 : 8'h00;
    return 8'((h % 256) + 90);
`endif
  endfunction

  task automatic tick();
    @(negedge clk_vga);
    n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({hs1, vs1, act1, fs1, col1, x1, y1} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'd0, 9'd0}) begin
        bad++;
        $display("FAIL reset_idle_lat1 cyc=%0d got hs=%b vs=%b act=%b fs=%b col=%h x=%0d y=%0d want 1 1 0 0 00 0 0",
                 i, hs1, vs1, act1, fs1, col1, x1, y1);
      end
      total++;
      if ({hs3, vs3, act3, fs3, col3, x3, y3} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'd0, 9'd0}) begin
        bad++;
        $display("FAIL reset_idle_lat3 cyc=%0d got hs=%b vs=%b act=%b fs=%b col=%h x=%0d y=%0d want 1 1 0 0 00 0 0",
                 i, hs3, vs3, act3, fs3, col3, x3, y3);
      end
    end
  endtask

  // Counters read (0,0) during the cycle after the last reset edge; n counts edges from there.
  task automatic test_first_pixel();
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (x1 !== 10'(n - 1)) begin
        bad++;
        $display("FAIL first_x n=%0d got %0d want %0d", n, x1, n - 1);
      end
      total++;
      if ({fs1, act1, col1} !== {(n == 3), (n >= 3), exp_col(n - 3, 1) & {8{n >= 3}}}) begin
        bad++;
        $display("FAIL first_pix_lat1 n=%0d got fs=%b act=%b col=%h want fs=%b act=%b",
                 n, fs1, act1, col1, (n == 3), (n >= 3));
      end
      total++;
      if ({fs3, act3, col3} !== {(n == 5), (n >= 5), exp_col(n - 5, 3) & {8{n >= 5}}}) begin
        bad++;
        $display("FAIL first_pix_lat3 n=%0d got fs=%b act=%b col=%h want fs=%b act=%b",
                 n, fs3, act3, col3, (n == 5), (n >= 5));
      end
    end
  endtask

  task automatic test_two_frames();
    int p, h, v, hfall, vfall, vf_cnt, fs_cnt, fs_at;
    logic e_act, e_hs, e_vs, e_fs, prev_hs, prev_vs;
    logic [7:0] e_col;
    logic [9:0] e_x;
    logic [8:0] e_y;
    hfall = -1; vfall = -1; vf_cnt = 0; fs_cnt = 0; fs_at = -1;
    prev_hs = hs1; prev_vs = vs1;
    while (n < 2 * FRAME) begin
      tick();
      p = n - 1; h = p % HT; v = (p / HT) % VT;
      e_x = (h < 640 && v < 6) ? 10'(h) : 10'd0;
      e_y = (h < 640 && v < 6) ? 9'(v) : 9'd0;
      total++;
      if ({x1, y1} !== {e_x, e_y}) begin
        bad++;
        $display("FAIL coord n=%0d got x=%0d y=%0d want x=%0d y=%0d", n, x1, y1, e_x, e_y);
      end
      p = n - 3; h = p % HT; v = (p / HT) % VT;
      e_act = (h < 640) && (v < 6);
      e_hs = !(h >= 656 && h <= 751);
      e_vs = !(v >= 8 && v <= 9);
      e_fs = e_act && h == 0 && v == 0;
      e_col = e_act ? exp_col(h, 1) : 8'h00;
      total++;
      if ({act1, hs1, vs1, fs1, col1} !== {e_act, e_hs, e_vs, e_fs, e_col}) begin
        bad++;
        $display("FAIL pins_lat1 n=%0d h=%0d v=%0d got act=%b hs=%b vs=%b fs=%b col=%h want %b %b %b %b %h",
                 n, h, v, act1, hs1, vs1, fs1, col1, e_act, e_hs, e_vs, e_fs, e_col);
      end
      p = n - 5; h = p % HT; v = (p / HT) % VT;
      e_act = (h < 640) && (v < 6);
      e_col = e_act ? exp_col(h, 3) : 8'h00;
      total++;
      if ({act3, hs3, vs3, fs3, col3} !== {e_act, !(h >= 656 && h <= 751), !(v >= 8 && v <= 9),
                                            e_act && h == 0 && v == 0, e_col}) begin
        bad++;
        $display("FAIL pins_lat3 n=%0d h=%0d v=%0d got act=%b hs=%b vs=%b fs=%b col=%h want act=%b col=%h",
                 n, h, v, act3, hs3, vs3, fs3, col3, e_act, e_col);
      end
      if (prev_hs && !hs1) begin
        total++;
        if ((hfall < 0 && n != 659) || (hfall >= 0 && n - hfall != 800)) begin
          bad++;
          $display("FAIL hsync_period n=%0d got prev fall %0d want period 800 (first at 659)", n, hfall);
        end
        hfall = n;
      end
      if (!prev_hs && hs1) begin
        total++;
        if (n - hfall != 96) begin
          bad++;
          $display("FAIL hsync_width n=%0d got %0d want 96", n, n - hfall);
        end
      end
      if (prev_vs && !vs1) begin
        total++;
        if ((vfall < 0 && n != 6403) || (vfall >= 0 && n - vfall != FRAME)) begin
          bad++;
          $display("FAIL vsync_period n=%0d got prev fall %0d want period %0d (first at 6403)", n, vfall, FRAME);
        end
        vfall = n;
        vf_cnt++;
      end
      if (!prev_vs && vs1) begin
        total++;
        if (n - vfall != 1600) begin
          bad++;
          $display("FAIL vsync_width n=%0d got %0d want 1600", n, n - vfall);
        end
      end
      if (fs1) begin
        fs_cnt++;
        fs_at = n;
      end
      prev_hs = hs1;
      prev_vs = vs1;
    end
    total++;
    if (vf_cnt != 2) begin
      bad++;
      $display("FAIL vsync_count got %0d want 2", vf_cnt);
    end
    total++;
    if (fs_cnt != 1 || fs_at != FRAME + 3) begin
      bad++;
      $display("FAIL frame_start_once got count=%0d at=%0d want count=1 at=%0d", fs_cnt, fs_at, FRAME + 3);
    end
  endtask

  // Reset lands while the counters read line 4, column 700 (inside hsync).
  task automatic test_midframe_reset();
    while (n % FRAME != 4 * HT + 700) tick();
    total++;
    if (hs1 !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_hsync got %b want 0", hs1);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({hs1, vs1, act1, fs1, col1, x1, y1} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'd0, 9'd0}) begin
      bad++;
      $display("FAIL midreset_lat1 got hs=%b vs=%b act=%b fs=%b col=%h x=%0d y=%0d want 1 1 0 0 00 0 0",
               hs1, vs1, act1, fs1, col1, x1, y1);
    end
    total++;
    if ({hs3, act3, col3} !== {1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL midreset_lat3 got hs=%b act=%b col=%h want 1 0 00", hs3, act3, col3);
    end
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if ({hs1, fs1, act1} !== {1'b1, (n == 3), (n >= 3)}) begin
        bad++;
        $display("FAIL restart_lat1 n=%0d got hs=%b fs=%b act=%b want 1 %b %b", n, hs1, fs1, act1, (n == 3), (n >= 3));
      end
      total++;
      if ({hs3, fs3, act3} !== {1'b1, (n == 5), (n >= 5)}) begin
        bad++;
        $display("FAIL restart_lat3 n=%0d got hs=%b fs=%b act=%b want 1 %b %b", n, hs3, fs3, act3, (n == 5), (n >= 5));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_first_pixel();
    test_two_frames();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
